// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder scheduler.
//   state_e   : scheduler FSM encoding (RUN / DRAIN / HALTED)
//   NO_IDLE / PUT_IDLE : values of the adder idle qualifier
//   DEF_LAT   : default adder latency in cycles
//   SIGN_BIT  : IEEE-754 single-precision sign bit index
package fp_add_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic NO_IDLE  = 1'b0;
  localparam logic PUT_IDLE = 1'b1;
  localparam int   DEF_LAT  = 5;
  localparam int   SIGN_BIT = 31;

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   valid_i     : request vector
//   en_i        : arbitration enable; no grant when low
//   ptr_i       : current priority pointer (highest-priority index)
//   grant_o     : one-hot grant (or zero)
//   grant_idx_o : index of the granted requester
//   grant_any_o : a grant was issued
//   ptr_d_o     : pointer value to load (granted index + 1 mod NREQ, else ptr_i)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic            en_i,
  input  logic [TAGW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TAGW-1:0] grant_idx_o,
  output logic            grant_any_o,
  output logic [TAGW-1:0] ptr_d_o
);

  // Each requester's distance from the pointer (mod NREQ); the valid one
  // with the smallest distance wins. All indexing uses loop constants.
  always_comb begin
    int best;
    int best_d;
    int d;
    best   = 0;
    best_d = NREQ;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(ptr_i) + NREQ) % NREQ;
      if (en_i && valid_i[i] && (d < best_d)) begin
        best_d = d;
        best   = i;
      end
    end
    grant_any_o = (best_d < NREQ);
    grant_o     = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = grant_any_o && (best == i);
    end
    grant_idx_o = grant_any_o ? TAGW'(best) : '0;
    ptr_d_o     = grant_any_o ? TAGW'((best + 1) % NREQ) : ptr_i;
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one pipelined FP adder between NREQ requesters.
//   req_*        : requester operation inputs, req_ready is the grant
//   adder_*      : operand/idle outputs to the adder, adder_result back
//   rsp_valid/rsp_data : one-hot routed result, no backpressure
//   halt/halted  : quiesce control, in_flight : issued-not-returned count
//   dbg_state    : FSM state for observation
//
// Handshake: a requester transfers an operation in the cycle where
// req_valid[i] & req_ready[i] are both high; req_ready is combinational
// from req_valid, the pointer and the FSM and is one-hot or zero. Responses
// are a single-cycle rsp_valid pulse and must be accepted.
module fp_add_scheduler
  import fp_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = DEF_LAT,
  parameter int TAGW = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        adder_a,
  output logic [31:0]        adder_b,
  output logic               adder_idle,
  input  logic [31:0]        adder_result,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_data,
  input  logic               halt,
  output logic               halted,
  output logic [3:0]         in_flight,
  output state_e             dbg_state
);

  state_e            state_q, state_d;
  logic              arb_en;
  logic [TAGW-1:0]   ptr_q, ptr_d, grant_idx;
  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [31:0]       sel_a, sel_b;
  logic              sel_sub;
  logic [31:0]       adder_a_q, adder_b_q;
  logic              adder_idle_q;
  logic [TAGW-1:0]   issue_tag_q;
  logic [LAT-1:0]    pipe_vld_q;
  logic [TAGW-1:0]   pipe_tag_q [LAT];
  logic              tail_vld;
  logic [TAGW-1:0]   tail_tag;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [3:0]        in_flight_q, in_flight_d;

  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
    .valid_i     (req_valid),
    .en_i        (arb_en),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (xfer),
    .ptr_d_o     (ptr_d)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt) state_d = DRAIN;
      DRAIN:   if (!halt) state_d = RUN;
               else if (in_flight_q == 4'd0) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs. Grants are cut combinationally in the cycle halt rises.
  always_comb begin
    arb_en = (state_q == RUN) && !halt;
    halted = (state_q == HALTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  // Issue stage: operands hold when idle so the adder inputs stay quiet.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adder_a_q    <= '0;
      adder_b_q    <= '0;
      adder_idle_q <= PUT_IDLE;
      issue_tag_q  <= '0;
    end else if (xfer) begin
      adder_a_q    <= sel_a;
      adder_b_q    <= {sel_b[SIGN_BIT] ^ sel_sub, sel_b[SIGN_BIT-1:0]};
      adder_idle_q <= NO_IDLE;
      issue_tag_q  <= grant_idx;
    end else begin
      adder_idle_q <= PUT_IDLE;
    end
  end

  // Tag pipe: entry k is the tag of the operation that entered the adder
  // k+1 cycles ago, so the tail lines up with adder_result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < LAT; k++) pipe_tag_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= ~adder_idle_q;
      pipe_tag_q[0] <= issue_tag_q;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
    end
  end

  assign tail_vld = pipe_vld_q[LAT-1];
  assign tail_tag = pipe_tag_q[LAT-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (tail_vld) begin
      rsp_valid_q <= NREQ'(1) << tail_tag;
      rsp_data_q  <= adder_result;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign in_flight_d = in_flight_q + 4'(xfer) - 4'(tail_vld);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) in_flight_q <= '0;
    else          in_flight_q <= in_flight_d;
  end

  assign req_ready  = grant;
  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign adder_idle = adder_idle_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign in_flight  = in_flight_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a lookup-table stand-in for the
// 5-cycle FP adder.
module tb_fp_add_scheduler;
  import fp_add_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [127:0]  req_a = '0;
  logic [127:0]  req_b = '0;
  logic [3:0]    req_sub = '0;
  logic [3:0]    req_ready;
  logic [31:0]   adder_a, adder_b, adder_result;
  logic          adder_idle;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic          halt = 1'b0;
  logic          halted;
  logic [3:0]    in_flight;
  state_e        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Requester i uses A=(i+1).0, B=1.0 in the bulk tests; result (i+2).0.
  logic [31:0] op_a [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] op_r [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  logic [31:0] model_q [LAT];

  always #5 clock = ~clock;

  fp_add_scheduler #(.NREQ(NREQ), .LAT(LAT), .TAGW(2)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_sub(req_sub), .req_ready(req_ready), .adder_a(adder_a),
    .adder_b(adder_b), .adder_idle(adder_idle), .adder_result(adder_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .halt(halt), .halted(halted),
    .in_flight(in_flight), .dbg_state(dbg_state)
  );

  // Adder stand-in: exact sums for the operand pairs used here.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'h40800000, 32'h3F800000}: return 32'h40A00000;
      {32'h40400000, 32'hBF800000}: return 32'h40000000;
      default:                      return 32'hFFFFFFFF;
    endcase
  endfunction

  always @(posedge clock) begin
    model_q[0] <= adder_idle ? 32'h0 : fadd(adder_a, adder_b);
    for (int k = 1; k < LAT; k++) model_q[k] <= model_q[k-1];
  end
  assign adder_result = model_q[LAT-1];

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i] = s;
  endtask

  task automatic set_bulk_ops();
    for (int i = 0; i < 4; i++) set_op(i, op_a[i], 32'h3F800000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (adder_a !== 32'h0) begin n_err++; $display("FAIL reset_adder_a: got %h want 0", adder_a); end
    n_vec++; if (adder_b !== 32'h0) begin n_err++; $display("FAIL reset_adder_b: got %h want 0", adder_b); end
    n_vec++; if (adder_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", adder_idle); end
    n_vec++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
    n_vec++; if (dbg_state !== RUN) begin n_err++; $display("FAIL reset_state: got %0d want RUN", dbg_state); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #1;
    n_vec++; if (adder_idle !== 1'b1) begin n_err++; $display("FAIL post_reset_idle: got %b want 1", adder_idle); end
  endtask

  // One operation from requester idx; checks issue, latency and routing.
  task automatic run_single(input string nm, input int idx, input logic [31:0] a,
                            input logic [31:0] b, input logic s,
                            input logic [31:0] exp_b, input logic [31:0] exp_res);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    @(negedge clock);
    set_op(idx, a, b, s);
    req_valid = oh;
    #1;
    n_vec++; if (req_ready !== oh) begin n_err++; $display("FAIL %s_ready: got %b want %b", nm, req_ready, oh); end
    @(negedge clock);
    req_valid = '0;
    #1;
    n_vec++; if (adder_idle !== 1'b0) begin n_err++; $display("FAIL %s_idle_low: got %b want 0", nm, adder_idle); end
    n_vec++; if (adder_a !== a) begin n_err++; $display("FAIL %s_adder_a: got %h want %h", nm, adder_a, a); end
    n_vec++; if (adder_b !== exp_b) begin n_err++; $display("FAIL %s_adder_b: got %h want %h", nm, adder_b, exp_b); end
    n_vec++; if (in_flight !== 4'd1) begin n_err++; $display("FAIL %s_in_flight1: got %0d want 1", nm, in_flight); end
    for (int c = 2; c <= 7; c++) begin
      @(negedge clock); #1;
      if (c == 2) begin
        n_vec++; if (adder_idle !== 1'b1) begin n_err++; $display("FAIL %s_idle_high: got %b want 1", nm, adder_idle); end
      end
      if (c < 7) begin
        n_vec++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL %s_early_rsp c=%0d: got %b want 0000", nm, c, rsp_valid); end
      end else begin
        n_vec++; if (rsp_valid !== oh) begin n_err++; $display("FAIL %s_rsp_valid: got %b want %b", nm, rsp_valid, oh); end
        n_vec++; if (rsp_data !== exp_res) begin n_err++; $display("FAIL %s_rsp_data: got %h want %h", nm, rsp_data, exp_res); end
        n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL %s_in_flight0: got %0d want 0", nm, in_flight); end
      end
    end
  endtask

  task automatic test_single_op();
    run_single("single", 0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
  endtask

  task automatic test_subtract();
    run_single("sub", 2, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_rdy;
    logic [31:0] exp_d;
    int          exp_if, done;
    do_reset();
    set_bulk_ops();
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        exp_rdy = 4'(1) << (c % 4);
        exp_q.push_back(op_r[c % 4]);
      end else exp_rdy = 4'h0;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
      done = (c - 6 < 0) ? 0 : ((c - 6 > 8) ? 8 : c - 6);
      exp_if = ((c < 8) ? c : 8) - done;
      n_vec++; if (in_flight !== 4'(exp_if)) begin n_err++; $display("FAIL rr_in_flight c=%0d: got %0d want %0d", c, in_flight, exp_if); end
      if (c >= 7 && c < 15) begin
        exp_rdy = 4'(1) << ((c - 7) % 4);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++; if (rsp_valid !== exp_rdy) begin n_err++; $display("FAIL rr_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rdy); end
        n_vec++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL rr_rsp_data c=%0d: got %h want %h", c, rsp_data, exp_d); end
      end else begin
        n_vec++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL rr_rsp_idle c=%0d: got %b want 0000", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_halt();
    logic [3:0]  exp_rdy, exp_rv;
    logic [31:0] exp_d;
    logic        exp_h;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      req_valid = (c <= 12) ? 4'hF : 4'h0;
      halt = (c >= 3 && c <= 10);
      #1;
      case (c)
        0: exp_rdy = 4'b0001;
        1: exp_rdy = 4'b0010;
        2: exp_rdy = 4'b0100;
        12: exp_rdy = 4'b1000;
        default: exp_rdy = 4'b0000;
      endcase
      exp_h = (c == 10 || c == 11);
      exp_d = 32'h0;
      case (c)
        7: begin exp_rv = 4'b0001; exp_d = 32'h40000000; end
        8: begin exp_rv = 4'b0010; exp_d = 32'h40400000; end
        9: begin exp_rv = 4'b0100; exp_d = 32'h40800000; end
        19: begin exp_rv = 4'b1000; exp_d = 32'h40A00000; end
        default: exp_rv = 4'b0000;
      endcase
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL halt_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_vec++; if (halted !== exp_h) begin n_err++; $display("FAIL halt_halted c=%0d: got %b want %b", c, halted, exp_h); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL halt_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rv); end
      if (exp_rv != 4'b0000) begin
        n_vec++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL halt_rsp_data c=%0d: got %h want %h", c, rsp_data, exp_d); end
      end
      if (c == 3) begin
        n_vec++; if (in_flight !== 4'd3) begin n_err++; $display("FAIL halt_in_flight3: got %0d want 3", in_flight); end
      end
      if (c == 4) begin
        n_vec++; if (dbg_state !== DRAIN) begin n_err++; $display("FAIL halt_state_drain: got %0d want DRAIN", dbg_state); end
      end
    end
  endtask

  task automatic test_drain_resume();
    logic [3:0]  exp_rdy, exp_rv;
    logic [31:0] exp_d;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clock);
      req_valid = (c <= 1 || c == 5) ? 4'hF : 4'h0;
      halt = (c == 2 || c == 3);
      #1;
      case (c)
        0: exp_rdy = 4'b0001;
        1: exp_rdy = 4'b0010;
        5: exp_rdy = 4'b0100;
        default: exp_rdy = 4'b0000;
      endcase
      exp_d = 32'h0;
      case (c)
        7: begin exp_rv = 4'b0001; exp_d = 32'h40000000; end
        8: begin exp_rv = 4'b0010; exp_d = 32'h40400000; end
        12: begin exp_rv = 4'b0100; exp_d = 32'h40800000; end
        default: exp_rv = 4'b0000;
      endcase
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL drain_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL drain_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rv); end
      if (exp_rv != 4'b0000) begin
        n_vec++; if (rsp_data !== exp_d) begin n_err++; $display("FAIL drain_rsp_data c=%0d: got %h want %h", c, rsp_data, exp_d); end
      end
      if (c == 4) begin
        n_vec++; if (dbg_state !== DRAIN) begin n_err++; $display("FAIL drain_state4: got %0d want DRAIN", dbg_state); end
      end
      if (c == 5) begin
        n_vec++; if (dbg_state !== RUN) begin n_err++; $display("FAIL drain_state5: got %0d want RUN", dbg_state); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] exp_rdy, exp_rv;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      case (c)
        0: req_valid = 4'b1001;
        1: req_valid = 4'b0001;
        13: req_valid = 4'b1001;
        default: req_valid = 4'b0000;
      endcase
      #1;
      case (c)
        0: exp_rdy = 4'b1000;
        1: exp_rdy = 4'b0001;
        13: exp_rdy = 4'b0001;
        default: exp_rdy = 4'b0000;
      endcase
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rst_ready c=%0d: got %b want %b", c, req_ready, exp_rdy); end
      if (c == 2) begin
        n_vec++; if (in_flight !== 4'd2) begin n_err++; $display("FAIL rst_pre_in_flight: got %0d want 2", in_flight); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (adder_a !== 32'h0) begin n_err++; $display("FAIL rst_adder_a: got %h want 0", adder_a); end
        n_vec++; if (adder_b !== 32'h0) begin n_err++; $display("FAIL rst_adder_b: got %h want 0", adder_b); end
        n_vec++; if (adder_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", adder_idle); end
        n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL rst_in_flight: got %0d want 0", in_flight); end
        n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        n_vec++; if (dbg_state !== RUN) begin n_err++; $display("FAIL rst_state: got %0d want RUN", dbg_state); end
        #1 reset_n = 1'b1;
      end
      exp_rv = (c == 20) ? 4'b0001 : 4'b0000;
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rst_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rv); end
      if (c == 20) begin
        n_vec++; if (rsp_data !== 32'h40000000) begin n_err++; $display("FAIL rst_rsp_data_after: got %h want 40000000", rsp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_subtract();
    test_back_to_back();
    test_halt();
    test_drain_resume();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no summary want summary");
    $fatal(1);
  end

endmodule
